// File: rtl/rv_namec_fetch.sv
// rv_namec_fetch: instruction fetch stage of the rv_namec core.
//
// It generates sequential word PCs and issues requests on the instruction-memory
// port (req/gnt/rvalid). A PC-tag queue pairs each in-order response with the
// address it answers, and a small in-order FIFO buffers the instructions for
// decode (valid/ready). A redirect from execute flushes the FIFO, loads a new
// PC and marks every request still in flight as stale so its response is
// discarded.
//
// Ports:
//   rv_namec_fetch_clock    single clock, rising edge
//   rv_namec_fetch_reset_n  synchronous active-low reset
//   fetch_enable            1 = issue new requests
//   redirect_valid/_pc      flush and restart at redirect_pc (bits [1:0] ignored)
//   imem_req/_addr/_gnt     request channel, word-aligned address
//   imem_rvalid/_rdata/_err in-order response channel
//   id_valid/_ready         handshake to decode
//   id_instr/_pc/_fault     head entry of the instruction buffer

module rv_namec_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        rv_namec_fetch_clock,
    input  logic        rv_namec_fetch_reset_n,
    input  logic        fetch_enable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_fault
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // Architectural state
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] tag_wptr_q, tag_wptr_d;
    logic [AW-1:0] tag_rptr_q, tag_rptr_d;

    // Storage (no reset needed: validity is tracked by the pointers/counters)
    logic [31:0]           instr_mem_q [FIFO_DEPTH];
    logic [31:0]           pc_mem_q    [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] err_mem_q;
    logic [31:0]           tag_mem_q   [FIFO_DEPTH];

    logic credit_ok;
    logic grant;
    logic rsp;
    logic rsp_drop;
    logic fifo_push;
    logic fifo_pop;
    logic fifo_nonempty;

    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Stale requests still hold credit until their response has come back.
    assign credit_ok = ({1'b0, count_q} + {1'b0, outst_q}) < {1'b0, DEPTH_C};

    assign imem_req  = rv_namec_fetch_reset_n & fetch_enable & credit_ok & ~redirect_valid;
    assign imem_addr = pc_q;
    assign grant     = imem_req & imem_gnt;

    // A response with nothing outstanding belongs to a pre-reset request.
    assign rsp       = imem_rvalid & (outst_q != '0);
    assign rsp_drop  = rsp & (drop_q != '0);
    assign fifo_push = rsp & (drop_q == '0) & ~redirect_valid;

    assign fifo_nonempty = (count_q != '0);
    assign id_valid      = fifo_nonempty & ~redirect_valid;
    assign fifo_pop      = id_valid & id_ready;

    assign id_instr = fifo_nonempty ? instr_mem_q[rptr_q] : 32'h0;
    assign id_pc    = fifo_nonempty ? pc_mem_q[rptr_q]    : 32'h0;
    assign id_fault = fifo_nonempty ? err_mem_q[rptr_q]   : 1'b0;

    always_comb begin
        pc_d       = pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        tag_wptr_d = tag_wptr_q;
        tag_rptr_d = tag_rptr_q;

        if (grant) begin
            pc_d       = pc_q + 32'd4;
            tag_wptr_d = tag_wptr_q + AW'(1);
        end
        if (rsp) begin
            tag_rptr_d = tag_rptr_q + AW'(1);
        end
        outst_d = outst_q + CW'(grant) - CW'(rsp);

        if (rsp_drop) begin
            drop_d = drop_q - CW'(1);
        end

        if (fifo_push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (fifo_pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        count_d = count_q + CW'(fifo_push) - CW'(fifo_pop);

        if (redirect_valid) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            // Everything still in flight after this edge is stale.
            drop_d  = outst_d;
            count_d = '0;
            rptr_d  = wptr_q;
            wptr_d  = wptr_q;
        end
    end

    always_ff @(posedge rv_namec_fetch_clock) begin
        if (!rv_namec_fetch_reset_n) begin
            pc_q       <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            tag_wptr_q <= '0;
            tag_rptr_q <= '0;
        end else begin
            pc_q       <= pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            tag_wptr_q <= tag_wptr_d;
            tag_rptr_q <= tag_rptr_d;
        end
    end

    always_ff @(posedge rv_namec_fetch_clock) begin
        if (fifo_push) begin
            instr_mem_q[wptr_q] <= imem_rdata;
            pc_mem_q[wptr_q]    <= tag_mem_q[tag_rptr_q];
            err_mem_q[wptr_q]   <= imem_err;
        end
        if (grant) begin
            tag_mem_q[tag_wptr_q] <= pc_q;
        end
    end

`ifndef SYNTHESIS
    // Credit accounting makes both overflows impossible.
    always_ff @(posedge rv_namec_fetch_clock) begin
        if (rv_namec_fetch_reset_n) begin
            assert (!(fifo_push && (count_q == DEPTH_C)));
            assert (!(grant && (outst_q == DEPTH_C)));
        end
    end
`endif

endmodule

// File: doc/rv_namec_fetch.md
Name: rv_namec_fetch

Overview:
Instruction fetch stage of the rv_namec core. It sits directly upstream of decode. It generates sequential PCs, issues word requests on the instruction-memory port using a req/gnt/rvalid handshake, and buffers returned instructions in a small in-order FIFO. It presents them to decode with a valid/ready handshake. Branch/jump redirects from execute flush the FIFO and discard in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
FIFO_DEPTH, 4, instruction buffer entries (power of 2, >=2); also the maximum of outstanding requests plus buffered entries

Ports:
rv_namec_fetch_clock  input  1  single clock; all logic on rising edge
rv_namec_fetch_reset_n  input  1  synchronous active-low reset
fetch_enable  input  1  1 = issue new requests; 0 = stop issuing, in-flight requests still complete
redirect_valid  input  1  redirect/flush request from execute
redirect_pc  input  32  new PC; bits [1:0] ignored (treated as 0)
imem_req  output  1  request valid
imem_addr  output  32  word address of request (bits [1:0] = 0)
imem_gnt  input  1  request accepted in this cycle when imem_req=1
imem_rvalid  input  1  response valid; responses return in order, at least 1 cycle after grant
imem_rdata  input  32  instruction word
imem_err  input  1  bus error qualifying imem_rvalid
id_valid  output  1  instruction available to decode
id_ready  input  1  decode accepts
id_instr  output  32  instruction
id_pc  output  32  PC of id_instr
id_fault  output  1  fetch bus error for this entry

Behaviour:
- Reset (reset_n=0 at an edge): pc<=RESET_PC, FIFO empty, outstanding=0, drop=0. Next cycle: imem_req=0 during reset, imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0, id_fault=0. Reset mid-operation discards all state; responses arriving after reset for pre-reset requests are not tracked (the bench must quiesce memory).
- Credit: credit_ok = (fifo_count + outstanding) < FIFO_DEPTH. Stale (to-be-dropped) requests count in outstanding.
- imem_req = fetch_enable & credit_ok & !redirect_valid. It is combinational from registered state; imem_addr = pc register.
- Grant (imem_req & imem_gnt): pc<=pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0x0), outstanding++. The request PC is pushed into a PC-tag queue of depth FIFO_DEPTH.
- Response (imem_rvalid):
  - If drop>0: drop--, outstanding--, pop the tag, nothing written.
  - Otherwise write {rdata, tag PC, imem_err} to the FIFO, outstanding--.
  - Credit guarantees the FIFO is never full on a write; overflow is impossible by construction (add an assertion).
- FIFO write-to-read latency: 1 cycle. An entry written at edge N is visible on id_* at cycle N+1.
- id_valid = fifo_nonempty & !redirect_valid. id_instr/id_pc/id_fault = head entry. Pop on id_valid & id_ready. Push and pop in the same cycle are allowed; count stays the same.
- Redirect (redirect_valid=1 at edge N):
  - FIFO cleared.
  - pc<=redirect_pc & ~3.
  - drop <= outstanding_next, i.e. outstanding after this edge's grant and response updates. A grant in the redirect cycle cannot occur because imem_req=0.
  - An imem_rvalid in the same cycle is dropped, as is the head entry (decode must not consume; id_valid is 0).
  - First request at the new PC is at cycle N+1 if credit allows.
- Simultaneous redirect_valid on consecutive cycles: the last one wins; drop recomputed each time.
- fetch_enable=0: no new requests; the FIFO drains normally; pc holds.
- Counter widths: outstanding and drop are $clog2(FIFO_DEPTH)+1 bits.
- imem_err entries are delivered normally with id_fault=1. Fetch continues sequentially; execute decides whether to redirect.

Test Plan:
- Reset: hold reset_n=0 3 cycles, release -> imem_req=1 with imem_addr=0x0 on the first cycle after release; id_valid=0.
- Streaming: gnt=1 always, rvalid 1 cycle after grant, rdata=addr^0xA5A5_0000, id_ready=1 -> id_pc sequence 0,4,8,… with matching id_instr; one instruction per cycle after a 2-cycle fill.
- Backpressure: id_ready=0, gnt=1, FIFO_DEPTH=4 -> exactly 4 grants (0x0–0xC), then imem_req=0. Raise id_ready -> req resumes at 0x10 with no loss or duplication.
- Redirect with 2 outstanding (latency 3): redirect_pc=0x100 -> both stale responses dropped; next id_pc=0x100; imem_addr=0x100 one cycle after redirect.
- Redirect coincident with rvalid and a nonempty FIFO -> id_valid=0 that cycle, FIFO empty next cycle, the rvalid word never appears; redirect_pc=0x203 fetches 0x200.
- imem_err=1 on the response for 0x8 -> id_pc=0x8 with id_fault=1; the 0xC entry has id_fault=0. PC wrap: RESET_PC=0xFFFF_FFF8 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
